// File: rtl/pong_game_ctrl.sv
// Pong game controller: button synchronizers, serve/play/point/over FSM,
// paddle and ball motion with wall/paddle collisions, all advanced once per frame.
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       frame_tick,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [8:0] paddle1_y,
    output logic [8:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state,
    output logic       winner
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    // 11-bit copies are for comparisons so sums can never wrap.
    localparam logic [10:0] STEP_W = 11'(PADDLE_STEP);
    localparam logic [10:0] PMAX_W = 11'(V_RES - PADDLE_H);
    localparam logic [10:0] VRES_W = 11'(V_RES);
    localparam logic [10:0] HRES_W = 11'(H_RES);
    localparam logic [10:0] BSZ_W  = 11'(BALL_SIZE);
    localparam logic [10:0] BSP_W  = 11'(BALL_SPEED);
    localparam logic [10:0] PH_W   = 11'(PADDLE_H);
    localparam logic [10:0] LHIT_W = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] RHIT_W = 11'(P2_X);

    localparam logic [8:0] STEP_N    = 9'(PADDLE_STEP);
    localparam logic [8:0] PMAX_N    = 9'(V_RES - PADDLE_H);
    localparam logic [8:0] BSP_Y     = 9'(BALL_SPEED);
    localparam logic [8:0] YMAX_N    = 9'(V_RES - BALL_SIZE);
    localparam logic [8:0] BALL_Y0   = 9'((V_RES - BALL_SIZE) / 2);
    localparam logic [8:0] PADDLE_Y0 = 9'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] BSP_X     = 10'(BALL_SPEED);
    localparam logic [9:0] LHIT_X    = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] RHIT_X    = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] XMAX_N    = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0] BALL_X0   = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [3:0] WIN_N     = 4'(WIN_SCORE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync_a, sync_b;
    logic          dx_q, dx_d, dy_q, dy_d, scorer_q, scorer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    paddle1_d, paddle2_d, ball_y_d;
    logic [9:0]    ball_x_d;
    logic [3:0]    score1_d, score2_d, new_score;
    logic          winner_d, enter_serve, frame_upd, any_btn;
    logic [8:0]    p1_mv, p2_mv, nxt_y;
    logic [9:0]    nxt_x;
    logic          nxt_dx, nxt_dy, miss, ov1, ov2;
    logic [10:0]   bx_w, by_w, ny_w, p1_w, p2_w;

    function automatic logic [8:0] move_paddle(input logic [8:0] y, input logic up,
                                               input logic dn);
        move_paddle = y;
        if (up && !dn)
            move_paddle = ({2'b0, y} >= STEP_W) ? y - STEP_N : 9'd0;
        else if (dn && !up)
            move_paddle = ({2'b0, y} + STEP_W > PMAX_W) ? PMAX_N : y + STEP_N;
    endfunction

    assign state     = state_q;
    assign frame_upd = frame_tick && ena;
    assign any_btn   = |sync_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a    <= '0;
            sync_b    <= '0;
            state_q   <= IDLE;
            paddle1_y <= PADDLE_Y0;
            paddle2_y <= PADDLE_Y0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            score1    <= '0;
            score2    <= '0;
            winner    <= 1'b0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b0;
            scorer_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_a    <= {p2_dn, p2_up, p1_dn, p1_up};
            sync_b    <= sync_a;
            state_q   <= state_d;
            paddle1_y <= paddle1_d;
            paddle2_y <= paddle2_d;
            ball_x    <= ball_x_d;
            ball_y    <= ball_y_d;
            score1    <= score1_d;
            score2    <= score2_d;
            winner    <= winner_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            scorer_q  <= scorer_d;
            cnt_q     <= cnt_d;
        end
    end

    // Candidate PLAY-frame motion: paddles first, then ball, then collisions.
    always_comb begin
        p1_mv  = move_paddle(paddle1_y, sync_b[0], sync_b[1]);
        p2_mv  = move_paddle(paddle2_y, sync_b[2], sync_b[3]);
        bx_w   = {1'b0, ball_x};
        by_w   = {2'b0, ball_y};
        nxt_y  = ball_y;
        nxt_dy = dy_q;
        if (!dy_q) begin
            if (by_w < BSP_W) begin
                nxt_y  = 9'd0;
                nxt_dy = 1'b1;
            end else begin
                nxt_y = ball_y - BSP_Y;
            end
        end else if (by_w + BSZ_W + BSP_W > VRES_W) begin
            nxt_y  = YMAX_N;
            nxt_dy = 1'b0;
        end else begin
            nxt_y = ball_y + BSP_Y;
        end
        ny_w = {2'b0, nxt_y};
        p1_w = {2'b0, p1_mv};
        p2_w = {2'b0, p2_mv};
        ov1  = (ny_w + BSZ_W > p1_w) && (ny_w < p1_w + PH_W);
        ov2  = (ny_w + BSZ_W > p2_w) && (ny_w < p2_w + PH_W);
        nxt_x  = ball_x;
        nxt_dx = dx_q;
        miss   = 1'b0;
        if (!dx_q) begin
            if (bx_w >= LHIT_W && bx_w <= LHIT_W + BSP_W && ov1) begin
                nxt_x  = LHIT_X;
                nxt_dx = 1'b1;
            end else if (bx_w < BSP_W) begin
                nxt_x = 10'd0;
                miss  = 1'b1;
            end else begin
                nxt_x = ball_x - BSP_X;
            end
        end else begin
            if (bx_w + BSZ_W <= RHIT_W && bx_w + BSZ_W + BSP_W >= RHIT_W && ov2) begin
                nxt_x  = RHIT_X;
                nxt_dx = 1'b0;
            end else if (bx_w + BSZ_W + BSP_W > HRES_W) begin
                nxt_x = XMAX_N;
                miss  = 1'b1;
            end else begin
                nxt_x = ball_x + BSP_X;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        paddle1_d   = paddle1_y;
        paddle2_d   = paddle2_y;
        ball_x_d    = ball_x;
        ball_y_d    = ball_y;
        score1_d    = score1;
        score2_d    = score2;
        winner_d    = winner;
        dx_d        = dx_q;
        dy_d        = dy_q;
        scorer_d    = scorer_q;
        cnt_d       = cnt_q;
        enter_serve = 1'b0;
        new_score   = (scorer_q ? score2 : score1) + 4'd1;
        if (frame_upd) begin
            unique case (state_q)
                IDLE: enter_serve = any_btn;
                SERVE: begin
                    paddle1_d = p1_mv;
                    paddle2_d = p2_mv;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) state_d = PLAY;
                end
                PLAY: begin
                    paddle1_d = p1_mv;
                    paddle2_d = p2_mv;
                    ball_x_d  = nxt_x;
                    ball_y_d  = nxt_y;
                    dx_d      = nxt_dx;
                    dy_d      = nxt_dy;
                    if (miss) begin
                        state_d  = POINT;
                        scorer_d = ~dx_q;
                    end
                end
                POINT: begin
                    if (scorer_q) score2_d = new_score;
                    else          score1_d = new_score;
                    if (new_score == WIN_N) begin
                        state_d  = OVER;
                        winner_d = scorer_q;
                    end else begin
                        enter_serve = 1'b1;
                    end
                end
                OVER: begin
                    if (any_btn) begin
                        score1_d    = 4'd0;
                        score2_d    = 4'd0;
                        enter_serve = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Serve aims at whoever conceded the last point; the first serve goes right.
        if (enter_serve) begin
            state_d  = SERVE;
            cnt_d    = CNT_LOAD;
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
            dy_d     = ~dy_q;
            dx_d     = (state_q == IDLE) ? 1'b1 : ~scorer_q;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: one scripted match with hand-traced
// ball/paddle positions checked at key frames via immediate assertions.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ena, frame_tick;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [8:0] paddle1_y, paddle2_y, ball_y;
    logic [9:0] ball_x;
    logic [3:0] score1, score2;
    logic [2:0] state;
    logic       winner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .frame_tick (frame_tick),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .paddle1_y  (paddle1_y),
        .paddle2_y  (paddle2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score1     (score1),
        .score2     (score2),
        .state      (state),
        .winner     (winner)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Buttons need two clocks through the synchronizer before a frame sees them.
    task automatic apply_stimulus(input logic u1, input logic d1, input logic u2,
                                  input logic d2);
        p1_up = u1;
        p1_dn = d1;
        p2_up = u2;
        p2_dn = d2;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check_output({tag, "_x"}, 32'(ball_x), x);
        check_output({tag, "_y"}, 32'(ball_y), y);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_state"}, 32'(state), 0);
        check_output({tag, "_p1"}, 32'(paddle1_y), 208);
        check_output({tag, "_p2"}, 32'(paddle2_y), 208);
        check_ball(tag, 316, 236);
        check_output({tag, "_s1"}, 32'(score1), 0);
        check_output({tag, "_s2"}, 32'(score2), 0);
        check_output({tag, "_win"}, 32'(winner), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        frame_tick = 1'b0;
        p1_up      = 1'b0;
        p1_dn      = 1'b0;
        p2_up      = 1'b0;
        p2_dn      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        $display("[TB] start game, count down the serve");
        apply_stimulus(1, 0, 0, 0);
        tick(1);
        check_output("idle_to_serve", 32'(state), 1);
        check_output("p1_frozen_idle", 32'(paddle1_y), 208);
        check_ball("serve_hold", 316, 236);
        tick(2);
        check_output("p1_moves_serve", 32'(paddle1_y), 200);
        apply_stimulus(0, 0, 0, 0);
        tick(57);
        check_output("still_serve", 32'(state), 1);
        tick(1);
        check_output("serve_to_play", 32'(state), 2);
        check_ball("play_start", 316, 236);

        $display("[TB] paddle saturation");
        apply_stimulus(1, 0, 0, 1);
        tick(50);
        check_output("p1_at_50", 32'(paddle1_y), 0);
        check_output("p2_at_50", 32'(paddle2_y), 408);
        tick(2);
        check_output("p2_at_52", 32'(paddle2_y), 416);
        tick(8);
        check_output("p1_hold_top", 32'(paddle1_y), 0);
        check_output("p2_hold_bot", 32'(paddle2_y), 416);
        check_ball("after_paddles", 436, 356);
        apply_stimulus(0, 0, 0, 0);

        $display("[TB] rally one: bottom wall, right paddle, top wall, left miss");
        tick(58);
        check_ball("bot_approach", 552, 472);
        tick(1);
        check_ball("bot_bounce", 554, 472);
        tick(1);
        check_ball("bot_leave", 556, 470);
        tick(25);
        check_ball("r_zone", 606, 420);
        tick(1);
        check_ball("r_hit", 608, 418);
        tick(1);
        check_ball("r_rebound", 606, 416);
        tick(207);
        check_ball("top_approach", 192, 2);
        tick(1);
        check_ball("top_reach", 190, 0);
        tick(1);
        check_ball("top_bounce", 188, 0);
        tick(1);
        check_ball("top_leave", 186, 2);
        tick(93);
        check_ball("l_edge", 0, 188);
        check_output("l_edge_state", 32'(state), 2);
        tick(1);
        check_output("l_miss_state", 32'(state), 3);
        check_ball("l_miss", 0, 190);
        check_output("l_miss_s2", 32'(score2), 0);
        tick(1);
        check_output("p2_point_state", 32'(state), 1);
        check_output("p2_point_s2", 32'(score2), 1);
        check_output("p2_point_s1", 32'(score1), 0);
        check_ball("p2_point_centre", 316, 236);

        $display("[TB] rally two: serve left, left paddle hit, right miss");
        tick(59);
        check_output("serve2_wait", 32'(state), 1);
        tick(1);
        check_output("serve2_play", 32'(state), 2);
        tick(118);
        check_ball("s2_top_reach", 80, 0);
        tick(1);
        check_ball("s2_top_bounce", 78, 0);
        tick(1);
        check_ball("s2_top_leave", 76, 2);
        tick(25);
        check_ball("l_zone", 26, 52);
        tick(1);
        check_ball("l_hit", 24, 54);
        tick(1);
        check_ball("l_rebound", 26, 56);
        tick(303);
        check_ball("r_edge", 632, 284);
        check_output("r_edge_state", 32'(state), 2);
        tick(1);
        check_output("r_miss_state", 32'(state), 3);
        check_output("r_miss_y", 32'(ball_y), 282);
        tick(1);
        check_output("p1_point_state", 32'(state), 1);
        check_output("p1_point_s1", 32'(score1), 1);
        check_output("p1_point_s2", 32'(score2), 1);

        $display("[TB] player 1 runs to the winning score");
        apply_stimulus(0, 0, 1, 0);
        tick(52);
        check_output("p2_centred", 32'(paddle2_y), 208);
        apply_stimulus(0, 0, 0, 0);
        tick(8);
        check_output("serve3_play", 32'(state), 2);
        tick(159);
        check_output("r3_miss_state", 32'(state), 3);
        check_ball("r3_miss", 632, 392);
        tick(1);
        check_output("r3_score", 32'(score1), 2);
        for (int k = 3; k <= 8; k++) begin
            tick(220);
            check_output("rally_s1", 32'(score1), 32'(k));
            check_output("rally_state", 32'(state), 1);
        end
        tick(60);
        check_output("final_play", 32'(state), 2);
        tick(159);
        check_output("final_point", 32'(state), 3);
        tick(1);
        check_output("over_state", 32'(state), 4);
        check_output("over_s1", 32'(score1), 9);
        check_output("over_s2", 32'(score2), 1);
        check_output("over_winner", 32'(winner), 0);
        check_ball("over_frozen", 632, 392);

        $display("[TB] enable gating and restart from OVER");
        ena = 1'b0;
        apply_stimulus(0, 1, 0, 0);
        tick(5);
        check_output("ena0_state", 32'(state), 4);
        check_output("ena0_s1", 32'(score1), 9);
        check_output("ena0_p1", 32'(paddle1_y), 0);
        check_ball("ena0_ball", 632, 392);
        ena = 1'b1;
        tick(1);
        check_output("restart_state", 32'(state), 1);
        check_output("restart_s1", 32'(score1), 0);
        check_output("restart_s2", 32'(score2), 0);
        check_output("restart_p1", 32'(paddle1_y), 0);
        check_output("restart_win", 32'(winner), 0);
        check_ball("restart_ball", 316, 236);
        apply_stimulus(0, 0, 0, 0);
        tick(60);
        check_output("restart_play", 32'(state), 2);
        tick(5);
        check_ball("restart_move", 326, 246);

        $display("[TB] reset in the middle of play");
        rst_n      = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst_n      = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameters: H_RES 640, horizontal pixels; V_RES 480, vertical pixels; PADDLE_H 64, paddle height; PADDLE_W 8, paddle width; P1_X 16, left paddle x; P2_X 616, right paddle x; BALL_SIZE 8, ball edge length; BALL_SPEED 2, ball px/frame per axis; PADDLE_STEP 4, paddle px/frame; SERVE_FRAMES 60, serve delay in frames; WIN_SCORE 9, winning score.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  design enable
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  raw asynchronous buttons
- paddle1_y, paddle2_y  out  9  paddle top edge
- ball_x  out  10  ball left edge
- ball_y  out  9  ball top edge
- score1, score2  out  4  player scores
- state  out  3  FSM state
- winner  out  1  0 = player 1, 1 = player 2; valid in OVER

Function
REQ-003 SHALL pass each button through a two-flop synchronizer; only synchronized values are used.
REQ-004 SHALL perform all game updates on the single clock edge where frame_tick=1 and ena=1 ("frame update"); outputs SHALL be stable otherwise.
REQ-005 SHALL ignore frame_tick while ena=0.
REQ-006 SHALL implement FSM: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-007 IDLE: at a frame update with any synchronized button high, go to SERVE and load the serve counter with SERVE_FRAMES.
REQ-008 SERVE: ball held at centre (x 316, y 236); counter decrements per frame update; at a frame update with counter=1, go to PLAY.
REQ-009 PLAY: each frame update moves the paddles, then the ball, then checks collisions, all committed on the same edge.
REQ-010 POINT: lasts exactly one frame update; that update increments the scorer's score; if the new score equals WIN_SCORE, go to OVER and set winner; else go to SERVE with counter reloaded.
REQ-011 OVER: positions frozen; at a frame update with any button high, clear both scores and go to SERVE.
REQ-012 Paddles move only in SERVE and PLAY.
- up alone: y := y>=PADDLE_STEP ? y-PADDLE_STEP : 0
- dn alone: y := min(y+PADDLE_STEP, V_RES-PADDLE_H)
- both or neither: hold
REQ-013 Ball direction SHALL use registered bits dx (1 = right) and dy (1 = down); each axis moves BALL_SPEED per PLAY frame update.
REQ-014 Vertical wall handling:
- dy=0 and y<BALL_SPEED: y:=0, dy:=1
- dy=1 and y+BALL_SIZE+BALL_SPEED>V_RES: y:=V_RES-BALL_SIZE, dy:=0
REQ-015 Paddle overlap SHALL be: ball_y+BALL_SIZE>paddle_y and ball_y<paddle_y+PADDLE_H, using post-move paddle_y.
REQ-016 Left paddle hit: dx=0, x>=P1_X+PADDLE_W, x-BALL_SPEED<=P1_X+PADDLE_W, overlap with paddle1 -> x:=P1_X+PADDLE_W, dx:=1.
REQ-017 Right paddle hit: dx=1, x+BALL_SIZE<=P2_X, x+BALL_SIZE+BALL_SPEED>=P2_X, overlap with paddle2 -> x:=P2_X-BALL_SIZE, dx:=0.
REQ-018 Misses:
- dx=0 and x<BALL_SPEED with no hit: x:=0, point to player 2, go POINT
- dx=1 and x+BALL_SIZE+BALL_SPEED>H_RES with no hit: x:=H_RES-BALL_SIZE, point to player 1, go POINT
REQ-019 On entry to SERVE, dx SHALL point toward the player who conceded the last point (toward player 2, dx=1, for the first serve), and dy SHALL toggle.
REQ-020 Position arithmetic SHALL use at least 11-bit intermediates; no wrap-around is permitted.

Reset
REQ-021 While rst_n=0 at a clk edge: state IDLE; paddle1_y = paddle2_y = 208; ball_x 316; ball_y 236; scores 0; winner 0; dx 1; dy 0; serve counter 0; synchronizers 0.
REQ-022 Reset SHALL take priority over frame_tick and ena, including mid-game.

Verification
REQ-023 Reset, then p1_up held, 3 frame ticks -> state goes IDLE->SERVE, then paddles do not move until SERVE; after SERVE_FRAMES ticks state=2.
REQ-024 PLAY, p1_up held 60 ticks from 208 -> paddle1_y reaches 0 and holds at 0; p2_dn held -> paddle2_y saturates at 416.
REQ-025 Ball at y=1, dy=0, one PLAY tick -> ball_y=0 and dy=1 (next tick ball_y=2).
REQ-026 Ball at x=26, dx=0, paddle1_y=208, ball_y=230, one tick -> ball_x=24, dx=1; same with paddle1_y=0 -> ball continues to x=0, POINT, score2=1, then SERVE with dx=0.
REQ-027 score1=8 and player 1 scores -> score1=9, state=4, winner=0; button press at next tick -> scores 0, state=1.
REQ-028 ena=0 with frame_tick pulses -> all outputs unchanged; rst_n low mid-PLAY -> all REQ-021 values on the next edge.
